// File: rtl/sha3_pkg.sv
// Shared Keccak/SHA-3 types and constants for the permutation datapath.
// Lane width, state width, tag width and the byte-reversal helper.
package sha3_pkg;

    localparam int LANE_W    = 64;
    localparam int STATE_W   = 1600;
    localparam int TAG_W     = 8;
    localparam int NUM_LANES = 25;

    typedef logic [LANE_W-1:0]  lane_t;
    typedef logic [STATE_W-1:0] state_t;
    typedef logic [TAG_W-1:0]   tag_t;

    // Reverses byte order within one lane (big-endian digest view).
    function automatic lane_t byte_rev(input lane_t x);
        lane_t r;
        for (int i = 0; i < LANE_W / 8; i++) begin
            r[8*i +: 8] = x[8*(LANE_W/8-1-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha3_digest_fifo2.sv
// Two-entry store of {tag, digest lanes}; exposes head and the entry behind it.
// The caller guarantees push only when there is room (or a pop happens).
module sha3_digest_fifo2
    import sha3_pkg::*;
#(
    parameter int DIGEST_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  tag_t                     wr_tag,
    input  lane_t [DIGEST_WORDS-1:0] wr_lanes,
    output tag_t                     head_tag,
    output lane_t [DIGEST_WORDS-1:0] head_lanes,
    output tag_t                     next_tag,
    output lane_t [DIGEST_WORDS-1:0] next_lanes,
    output logic                     full,
    output logic                     empty
);

    tag_t                     mem_tag   [2];
    lane_t [DIGEST_WORDS-1:0] mem_lanes [2];

    logic       wp;
    logic       rp;
    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) begin
                wp <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // When full, wp == rp: a same-cycle push reuses the slot being popped.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_tag[wp]   <= wr_tag;
            mem_lanes[wp] <= wr_lanes;
        end
    end

    assign head_tag   = mem_tag[rp];
    assign head_lanes = mem_lanes[rp];
    assign next_tag   = mem_tag[~rp];
    assign next_lanes = mem_lanes[~rp];
    assign full       = (cnt == 2'd2);
    assign empty      = (cnt == 2'd0);

endmodule

// File: rtl/sha3_digest_squeeze.sv
// Catches finished Keccak states and serialises digest lanes on push/stop.
// Build option SHA3_SQUEEZE_BYTESWAP_EN: present each lane byte-reversed.
module sha3_digest_squeeze
    import sha3_pkg::*;
#(
    parameter int DIGEST_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pushin,
    input  state_t      din,
    input  tag_t        tagin,
    input  logic        stopin,
    output logic        pushout,
    output lane_t       dout,
    output tag_t        tagout,
    output logic [2:0]  dixout,
    output logic        lastout,
    output logic        overflow
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;
    localparam logic [2:0] LAST_IDX = 3'(DIGEST_WORDS - 1);

    logic [0:0] state;
    logic [2:0] idx;
    logic [2:0] idx_n;

    lane_t [DIGEST_WORDS-1:0] cap_lanes;
    tag_t                     head_tag;
    lane_t [DIGEST_WORDS-1:0] head_lanes;
    tag_t                     next_tag;
    lane_t [DIGEST_WORDS-1:0] next_lanes;
    logic                     full;
    logic                     empty;

    logic  accept;
    logic  last_word;
    logic  pop;
    logic  push_ok;
    logic  drop;
    logic  busy_n;
    tag_t  nh_tag;
    lane_t [DIGEST_WORDS-1:0] nh_lanes;
    lane_t sel_lane;
    lane_t sel_fmt;
    logic  unused_hi;

    always_comb begin
        cap_lanes = '0;
        for (int i = 0; i < DIGEST_WORDS; i++) begin
            cap_lanes[i] = din[LANE_W*i +: LANE_W];
        end
    end

    assign unused_hi = ^din[STATE_W-1:LANE_W*DIGEST_WORDS];

    assign accept    = (state == S_SEND) && !stopin;
    assign last_word = (idx == LAST_IDX);
    assign pop       = accept && last_word;
    assign push_ok   = pushin && (!full || pop);
    assign drop      = pushin && full && !pop;
    assign busy_n    = push_ok || full || (!empty && !pop);

    always_comb begin
        idx_n = idx;
        if (accept) begin
            idx_n = last_word ? 3'd0 : idx + 3'd1;
        end
    end

    // Head as it will stand after this edge, so outputs load in one step.
    always_comb begin
        nh_tag   = head_tag;
        nh_lanes = head_lanes;
        if (pop) begin
            if (full) begin
                nh_tag   = next_tag;
                nh_lanes = next_lanes;
            end else begin
                nh_tag   = tagin;
                nh_lanes = cap_lanes;
            end
        end else if (empty) begin
            nh_tag   = tagin;
            nh_lanes = cap_lanes;
        end
    end

    always_comb begin
        sel_lane = '0;
        for (int i = 0; i < DIGEST_WORDS; i++) begin
            if (idx_n == 3'(i)) begin
                sel_lane = nh_lanes[i];
            end
        end
    end

`ifdef SHA3_SQUEEZE_BYTESWAP_EN
    assign sel_fmt = byte_rev(sel_lane);
`else
    assign sel_fmt = sel_lane;
`endif

    sha3_digest_fifo2 #(
        .DIGEST_WORDS(DIGEST_WORDS)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_ok),
        .pop        (pop),
        .wr_tag     (tagin),
        .wr_lanes   (cap_lanes),
        .head_tag   (head_tag),
        .head_lanes (head_lanes),
        .next_tag   (next_tag),
        .next_lanes (next_lanes),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= 3'd0;
            overflow <= 1'b0;
            dout     <= '0;
            tagout   <= '0;
            dixout   <= 3'd0;
            lastout  <= 1'b0;
        end else begin
            state    <= busy_n ? S_SEND : S_IDLE;
            idx      <= idx_n;
            overflow <= overflow | drop;
            if (busy_n) begin
                dout    <= sel_fmt;
                tagout  <= nh_tag;
                dixout  <= idx_n;
                lastout <= (idx_n == LAST_IDX);
            end
        end
    end

    assign pushout = (state == S_SEND);

endmodule

// File: doc/sha3_digest_squeeze.md
Name: sha3_digest_squeeze

Overview:
- Output-side consumer of the Keccak permutation controller.
- Catches each finished 1600-bit state, which arrives as a single-cycle pulse with no backpressure, together with its 8-bit tag.
- Buffers up to two results and serialises the digest lanes as 64-bit words on a push/stop handshake.
- Sits between the permutation core and the host/output interface.

Parameters:
- DIGEST_WORDS, 4, number of 64-bit lanes emitted per result. Legal range 1..8; 4 = SHA3-256, 8 = SHA3-512.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- pushin  input  1  one-cycle pulse from the permutation core: din/tagin valid this cycle.
- din  input  1600  final Keccak state; lane i = din[64*i+63:64*i].
- tagin  input  8  tag accompanying din.
- stopin  input  1  downstream stall; while high, the current output word is held.
- pushout  output  1  dout/tagout/dixout/lastout valid.
- dout  output  64  current digest word.
- tagout  output  8  tag of the digest being sent.
- dixout  output  3  word index within the digest, 0..DIGEST_WORDS-1.
- lastout  output  1  high with the final word of a digest.
- overflow  output  1  sticky flag: a result was dropped.

Behaviour:
- Reset values: pushout=0, dout=0, tagout=0, dixout=0, lastout=0, overflow=0, FIFO empty, state IDLE. Reset applies only on a clk edge and overrides all other events in that cycle.
- Reset mid-digest: the partial digest is discarded and no further words of it are emitted.
- Capture:
  - On posedge with pushin=1, store lanes 0..DIGEST_WORDS-1 of din plus tagin into a 2-entry FIFO.
  - Lanes above DIGEST_WORDS-1 are ignored.
- Latency: a capture into an empty FIFO while IDLE gives pushout=1 on the next cycle, with dixout=0.
- Output FSM, two states:
  - IDLE: pushout=0. Go to SEND when the FIFO is non-empty.
  - SEND: pushout=1, dout=head lane[idx], tagout=head tag, dixout=idx, lastout=(idx==DIGEST_WORDS-1).
- Word transfer: a word is accepted on a cycle with pushout=1 and stopin=0; idx then increments.
- Stall: with stopin=1, all outputs hold stable and idx is unchanged.
- End of digest: on acceptance of the last word, pop the head and reset idx to 0.
  - If another entry remains, or one is captured that same cycle, stay in SEND with no bubble cycle.
  - Otherwise go to IDLE.
- Output registering: dout, tagout, dixout, lastout may be a mux of FIFO head and idx, but every select and storage element is registered. There are no combinational paths from inputs to outputs.
- Full FIFO:
  - pushin while FIFO holds 2 entries and no pop occurs that cycle: drop the new result, set overflow=1, stored data unchanged.
  - Simultaneous pop (last word accepted) and pushin when full: the push is accepted and no overflow occurs.
- overflow clears only on reset.
- Outputs when not pushing: dout/tagout/dixout/lastout hold their last values; downstream must ignore them.
- DIGEST_WORDS=1: every word has lastout=1 and each word pops.

Optional Feature:
- Macro: SHA3_SQUEEZE_BYTESWAP_EN.
- Defined: dout presents each lane byte-reversed (dout[7:0] = lane[63:56], ...), giving big-endian digest byte order.
- Undefined: lane passed through unchanged (little-endian Keccak lane order).
- tagout, dixout and all handshake behaviour are identical in both builds.

Decomposition:
- Shared package sha3_pkg: LANE_W=64, STATE_W=1600, TAG_W=8, NUM_LANES=25, lane typedef, and the state_t/tag_t typedefs shared with the permutation controller.
- Sub-module sha3_digest_fifo2: 2-entry storage of {tag, DIGEST_WORDS lanes} with full/empty, push/pop, and head read.
- FSM, idx counter and overflow logic stay in the top module.

Test Plan:
- Single result, DIGEST_WORDS=4:
  - Stimulus: pushin with lane i = 64'h1111_1111_1111_1111*(i+1), tagin=8'hA5, stopin=0.
  - Response: pushout high for exactly 4 cycles starting 1 cycle after pushin; dixout 0,1,2,3; lastout only on word 3; tagout=A5 throughout; overflow=0.
- Back-to-back results:
  - Stimulus: two pushin pulses 2 cycles apart, tags 01 and 02.
  - Response: 8 contiguous pushout cycles with no bubble; tag switches 01→02 at dixout=0 of the second digest.
- Stall:
  - Stimulus: stopin=1 for 3 cycles while dixout=1.
  - Response: dout, dixout and lastout are held; sequence resumes at 1,2,3; no words are lost or duplicated.
- Overflow:
  - Stimulus: stopin=1 held; pushin three times with tags 10, 11, 12.
  - Response: overflow=1 after the third push; on release, digests 10 then 11 are emitted and 12 never appears.
- Full plus simultaneous pop:
  - Stimulus: FIFO full; pushin on the cycle the last word of the head is accepted.
  - Response: the new digest is emitted after the remaining one; overflow stays 0.
- Reset mid-digest:
  - Stimulus: assert reset for 1 cycle at dixout=2.
  - Response: next cycle all outputs are 0 and FIFO is empty; a subsequent pushin restarts at dixout=0.
  - Run once with SHA3_SQUEEZE_BYTESWAP_EN defined: lane 64'h0102030405060708 yields dout=64'h0807060504030201.
